alu_seq: RTL

//  Parametrised, multi-cycle ALU for the cpuy datapath. Width is set by WIDTH.

---
 rtl/alu_seq.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU for the cpuy datapath: single-cycle logic/arith ops, shift-add MUL and
// restoring DIV, with valid/ready handshakes on both sides and registered, non-sticky flags.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_l,
  output logic [WIDTH-1:0] result_h,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int HW = WIDTH / 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [WIDTH-1:0]   mp_q, mp_d, rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0]   res_l_q, res_l_d, res_h_q, res_h_d;
  logic               carry_q, carry_d, zero_q, zero_d, sign_q, sign_d;

  logic [WIDTH-1:0]   sc_l, sc_h;
  logic               sc_c, sc_s, sc_z, is_multi;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     trial, rem_full;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx;
  logic               div_unused;

  // Single-cycle results, computed straight from the accepted operands
  always_comb begin
    sc_l = '0;
    sc_h = '0;
    sc_c = 1'b0;
    sc_s = 1'b0;
    sum  = '0;
    case (opcode)
      4'd0: begin
        sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, carry_in};
        {sc_c, sc_l} = sum;
      end
      4'd1, 4'd15: begin
        if (op_a < op_b) begin
          sc_l = op_b - op_a;
          sc_s = 1'b1;
        end else begin
          sc_l = op_a - op_b;
        end
        if (opcode == 4'd15) begin
          sc_l = '0;
        end else begin
          sc_l = sc_l;
        end
      end
      4'd3: begin
        // Only reached as a single-cycle op when dividing by zero
        sc_l = '1;
        sc_h = op_a;
        sc_c = 1'b1;
      end
      4'd4: sc_l = op_a & op_b;
      4'd5: sc_l = op_a | op_b;
      4'd6: sc_l = op_a ^ op_b;
      4'd7: sc_l = ~op_a;
      4'd8: begin
        sum = {1'b0, op_a} + {{WIDTH{1'b0}}, 1'b1};
        {sc_c, sc_l} = sum;
      end
      4'd9: begin
        sc_l = op_a - {{(WIDTH-1){1'b0}}, 1'b1};
        sc_s = (op_a == '0);
      end
      4'd10: sc_l = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
      4'd11: sc_l = {op_a[0], op_a[WIDTH-1:1]};
      4'd12: begin
        sc_l = {op_a[WIDTH-2:0], carry_in};
        sc_c = op_a[WIDTH-1];
      end
      4'd13: begin
        sc_l = {carry_in, op_a[WIDTH-1:1]};
        sc_c = op_a[0];
      end
      4'd14: sc_l = {op_a[HW-1:0], op_a[WIDTH-1:HW]};
      default: begin
        sc_l = '0;
        sc_h = '0;
      end
    endcase
    if (opcode == 4'd15) begin
      sc_z = (op_a == op_b);
    end else begin
      sc_z = ({sc_h, sc_l} == '0);
    end
    is_multi = (opcode == 4'd2) || ((opcode == 4'd3) && (op_b != '0));
  end

  // One MUL/DIV iteration; the shifted partial remainder is WIDTH+1 bits
  always_comb begin
    mul_sum    = acc_q + (mp_q[0] ? mc_q : '0);
    trial      = {rem_q, quo_q[WIDTH-1]};
    div_ge     = (trial >= {1'b0, b_q});
    rem_full   = div_ge ? (trial - {1'b0, b_q}) : trial;
    rem_nx     = rem_full[WIDTH-1:0];
    div_unused = rem_full[WIDTH];
    quo_nx     = {quo_q[WIDTH-2:0], div_ge};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = is_multi ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    case (state_q)
      IDLE:    {in_ready, out_valid, busy} = 3'b100;
      RUN:     {in_ready, out_valid, busy} = 3'b001;
      DONE:    {in_ready, out_valid, busy} = 3'b010;
      default: {in_ready, out_valid, busy} = 3'b000;
    endcase
  end

  // Datapath and result register updates
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    res_l_d  = res_l_q;
    res_h_d  = res_h_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    if ((state_q == IDLE) && in_valid) begin
      if (is_multi) begin
        cnt_d    = CW'(WIDTH - 1);
        is_div_d = opcode[0];
        b_d      = op_b;
        acc_d    = '0;
        mc_d     = {{WIDTH{1'b0}}, op_a};
        mp_d     = op_b;
        rem_d    = '0;
        quo_d    = op_a;
      end else begin
        res_l_d = sc_l;
        res_h_d = sc_h;
        carry_d = sc_c;
        zero_d  = sc_z;
        sign_d  = sc_s;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      acc_d = mul_sum;
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      rem_d = rem_nx;
      quo_d = quo_nx;
      if (cnt_q == '0) begin
        if (is_div_q) begin
          res_l_d = quo_nx;
          res_h_d = rem_nx;
        end else begin
          {res_h_d, res_l_d} = mul_sum;
        end
        carry_d = 1'b0;
        sign_d  = 1'b0;
        zero_d  = is_div_q ? ({rem_nx, quo_nx} == '0) : (mul_sum == '0);
      end else begin
        zero_d = zero_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      res_l_q  <= '0;
      res_h_q  <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      res_l_q  <= res_l_d;
      res_h_q  <= res_h_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign result_l = res_l_q;
  assign result_h = res_h_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign sign     = sign_q;
endmodule
